// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU and MDR-select codes, the sequencer state encoding and the
// control-strobe bundle used between the sequencer and its output decoder.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'h00;
    localparam logic [4:0] OP_LDI  = 5'h01;
    localparam logic [4:0] OP_ST   = 5'h02;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_ADDI = 5'h0C;
    localparam logic [4:0] OP_ANDI = 5'h0D;
    localparam logic [4:0] OP_ORI  = 5'h0E;
    localparam logic [4:0] OP_BR   = 5'h12;
    localparam logic [4:0] OP_JR   = 5'h13;
    localparam logic [4:0] OP_IN   = 5'h16;
    localparam logic [4:0] OP_OUT  = 5'h17;
    localparam logic [4:0] OP_MFHI = 5'h18;
    localparam logic [4:0] OP_MFLO = 5'h19;
    localparam logic [4:0] OP_NOP  = 5'h1A;
    localparam logic [4:0] OP_HALT = 5'h1B;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd8;
    localparam logic [3:0] ALU_SUB  = 4'd9;

    localparam logic [1:0] MDR_BUS = 2'b00;
    localparam logic [1:0] MDR_MEM = 2'b01;
    localparam logic [1:0] MDR_IMM = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU, CL_IMM, CL_LD, CL_ST, CL_BR, CL_JR,
        CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
    } op_class_t;

    typedef struct packed {
        logic       Run;
        logic       PCout;
        logic       Zlowout;
        logic       Zhighout;
        logic       MDRout;
        logic       HIout;
        logic       LOout;
        logic       InPortout;
        logic       Cout;
        logic       BAout;
        logic       Rout;
        logic       MARin;
        logic       PCin;
        logic       MDRin;
        logic       IRin;
        logic       Yin;
        logic       Zlowin;
        logic       Zhighin;
        logic       HIin;
        logic       LOin;
        logic       OutPortin;
        logic       Rin;
        logic       GRA;
        logic       GRB;
        logic       GRC;
        logic       CONin;
        logic       IncPc;
        logic       read;
        logic       write;
        logic [1:0] mdr_read;
        logic [3:0] control;
    } ctrl_t;

    // ldi reuses the addi sequence; undefined opcodes behave as nop.
    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR:     return CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  return CL_IMM;
            OP_LD:                             return CL_LD;
            OP_ST:                             return CL_ST;
            OP_BR:                             return CL_BR;
            OP_JR:                             return CL_JR;
            OP_IN:                             return CL_IN;
            OP_OUT:                            return CL_OUT;
            OP_MFHI:                           return CL_MFHI;
            OP_MFLO:                           return CL_MFLO;
            OP_HALT:                           return CL_HALT;
            default:                           return CL_NOP;
        endcase
    endfunction

    function automatic logic [3:0] alu_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LDI, OP_LD, OP_ST: return ALU_ADD;
            OP_SUB:                                return ALU_SUB;
            OP_AND, OP_ANDI:                       return ALU_AND;
            OP_OR, OP_ORI:                         return ALU_OR;
            default:                               return ALU_NONE;
        endcase
    endfunction

    function automatic state_t last_step(input op_class_t c);
        case (c)
            CL_ALU, CL_IMM: return ST_T5;
            CL_BR:          return ST_T6;
            CL_LD, CL_ST:   return ST_T7;
            default:        return ST_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer (master) and the single-bus datapath (slave):
// IR/Branch/stop flow into the sequencer, Run and the transfer strobes flow out.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        Branch;
    logic        stop;
    logic        Run;
    logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin, Rin;
    logic        GRA, GRB, GRC, CONin, IncPc, read, write;
    logic [1:0]  mdr_read;
    logic [3:0]  control;

    modport master (
        input  IR, Branch, stop,
        output Run, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
               MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin, Rin,
               GRA, GRB, GRC, CONin, IncPc, read, write, mdr_read, control
    );

    modport slave (
        output IR, Branch, stop,
        input  Run, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
               MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin, Rin,
               GRA, GRB, GRC, CONin, IncPc, read, write, mdr_read, control
    );
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decode: (state, opcode, Branch) -> register-transfer strobes.
// Branch only matters in the T6 step of br, where it gates PCin.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [4:0] opcode_i,
    input  logic       branch_i,
    output ctrl_t      ctrl_o
);

    op_class_t cls;
    assign cls = op_class(opcode_i);

    always_comb begin
        ctrl_o     = '0;
        ctrl_o.Run = (state_i != ST_IDLE) && (state_i != ST_HALT);
        case (state_i)
            ST_T0: begin
                ctrl_o.PCout = 1'b1; ctrl_o.MARin = 1'b1; ctrl_o.IncPc = 1'b1; ctrl_o.Zlowin = 1'b1;
            end
            ST_T1: begin
                ctrl_o.Zlowout = 1'b1; ctrl_o.PCin = 1'b1; ctrl_o.read = 1'b1;
                ctrl_o.mdr_read = MDR_MEM; ctrl_o.MDRin = 1'b1;
            end
            ST_T2: begin
                ctrl_o.MDRout = 1'b1; ctrl_o.IRin = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CL_ALU: begin ctrl_o.GRB = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.Yin = 1'b1; end
                    CL_IMM, CL_LD, CL_ST: begin
                        ctrl_o.GRB = 1'b1; ctrl_o.BAout = 1'b1; ctrl_o.Yin = 1'b1;
                    end
                    CL_BR:   begin ctrl_o.GRA = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.CONin = 1'b1; end
                    CL_JR:   begin ctrl_o.GRA = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.PCin = 1'b1; end
                    CL_IN:   begin ctrl_o.InPortout = 1'b1; ctrl_o.GRA = 1'b1; ctrl_o.Rin = 1'b1; end
                    CL_OUT:  begin ctrl_o.GRA = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.OutPortin = 1'b1; end
                    CL_MFHI: begin ctrl_o.HIout = 1'b1; ctrl_o.GRA = 1'b1; ctrl_o.Rin = 1'b1; end
                    CL_MFLO: begin ctrl_o.LOout = 1'b1; ctrl_o.GRA = 1'b1; ctrl_o.Rin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_ALU: begin
                        ctrl_o.GRC = 1'b1; ctrl_o.Rout = 1'b1;
                        ctrl_o.control = alu_op(opcode_i); ctrl_o.Zlowin = 1'b1;
                    end
                    CL_IMM, CL_LD, CL_ST: begin
                        ctrl_o.Cout = 1'b1; ctrl_o.control = alu_op(opcode_i); ctrl_o.Zlowin = 1'b1;
                    end
                    CL_BR:   begin ctrl_o.PCout = 1'b1; ctrl_o.Yin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_ALU, CL_IMM: begin ctrl_o.Zlowout = 1'b1; ctrl_o.GRA = 1'b1; ctrl_o.Rin = 1'b1; end
                    CL_LD, CL_ST:   begin ctrl_o.Zlowout = 1'b1; ctrl_o.MARin = 1'b1; end
                    CL_BR: begin
                        ctrl_o.Cout = 1'b1; ctrl_o.control = ALU_ADD; ctrl_o.Zlowin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CL_LD: begin ctrl_o.read = 1'b1; ctrl_o.mdr_read = MDR_MEM; ctrl_o.MDRin = 1'b1; end
                    CL_ST: begin
                        ctrl_o.GRA = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.mdr_read = MDR_BUS; ctrl_o.MDRin = 1'b1;
                    end
                    CL_BR:   begin ctrl_o.Zlowout = 1'b1; ctrl_o.PCin = branch_i; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CL_LD:   begin ctrl_o.MDRout = 1'b1; ctrl_o.GRA = 1'b1; ctrl_o.Rin = 1'b1; end
                    CL_ST:   ctrl_o.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: falling-edge step counter T0..T7 with IDLE/HALT supervision;
// strobes come from ctrl_decode so datapath registers see them stable at the rising edge.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    state_t          state_q, state_d;
    logic [OPW-1:0]  opcode;
    op_class_t       cls;
    ctrl_t           ctrl;

    assign opcode = bus.IR[31 -: OPW];
    assign cls    = op_class(opcode);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // stop is only honoured on the edge that closes an instruction's last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: begin
                if (state_q == last_step(cls)) begin
                    if (cls == CL_HALT || bus.stop) state_d = ST_HALT;
                    else                            state_d = ST_T0;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
        endcase
    end

    ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode),
        .branch_i (bus.Branch),
        .ctrl_o   (ctrl)
    );

    assign bus.Run       = ctrl.Run;
    assign bus.PCout     = ctrl.PCout;
    assign bus.Zlowout   = ctrl.Zlowout;
    assign bus.Zhighout  = ctrl.Zhighout;
    assign bus.MDRout    = ctrl.MDRout;
    assign bus.HIout     = ctrl.HIout;
    assign bus.LOout     = ctrl.LOout;
    assign bus.InPortout = ctrl.InPortout;
    assign bus.Cout      = ctrl.Cout;
    assign bus.BAout     = ctrl.BAout;
    assign bus.Rout      = ctrl.Rout;
    assign bus.MARin     = ctrl.MARin;
    assign bus.PCin      = ctrl.PCin;
    assign bus.MDRin     = ctrl.MDRin;
    assign bus.IRin      = ctrl.IRin;
    assign bus.Yin       = ctrl.Yin;
    assign bus.Zlowin    = ctrl.Zlowin;
    assign bus.Zhighin   = ctrl.Zhighin;
    assign bus.HIin      = ctrl.HIin;
    assign bus.LOin      = ctrl.LOin;
    assign bus.OutPortin = ctrl.OutPortin;
    assign bus.Rin       = ctrl.Rin;
    assign bus.GRA       = ctrl.GRA;
    assign bus.GRB       = ctrl.GRB;
    assign bus.GRC       = ctrl.GRC;
    assign bus.CONin     = ctrl.CONin;
    assign bus.IncPc     = ctrl.IncPc;
    assign bus.read      = ctrl.read;
    assign bus.write     = ctrl.write;
    assign bus.mdr_read  = ctrl.mdr_read;
    assign bus.control   = ctrl.control;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: each issued instruction pushes its expected per-cycle strobe
// vectors; a monitor pops one per rising edge and compares against the DUT.
module tb_control_sequencer;

    typedef logic [34:0] vec_t;

    localparam vec_t PCOUT     = vec_t'(1) << 0;
    localparam vec_t ZLOWOUT   = vec_t'(1) << 1;
    localparam vec_t ZHIGHOUT  = vec_t'(1) << 2;
    localparam vec_t MDROUT    = vec_t'(1) << 3;
    localparam vec_t HIOUT     = vec_t'(1) << 4;
    localparam vec_t LOOUT     = vec_t'(1) << 5;
    localparam vec_t INPORTOUT = vec_t'(1) << 6;
    localparam vec_t COUT      = vec_t'(1) << 7;
    localparam vec_t BAOUT     = vec_t'(1) << 8;
    localparam vec_t ROUT      = vec_t'(1) << 9;
    localparam vec_t MARIN     = vec_t'(1) << 10;
    localparam vec_t PCIN      = vec_t'(1) << 11;
    localparam vec_t MDRIN     = vec_t'(1) << 12;
    localparam vec_t IRIN      = vec_t'(1) << 13;
    localparam vec_t YIN       = vec_t'(1) << 14;
    localparam vec_t ZLOWIN    = vec_t'(1) << 15;
    localparam vec_t ZHIGHIN   = vec_t'(1) << 16;
    localparam vec_t HIIN      = vec_t'(1) << 17;
    localparam vec_t LOIN      = vec_t'(1) << 18;
    localparam vec_t OUTPORTIN = vec_t'(1) << 19;
    localparam vec_t RIN       = vec_t'(1) << 20;
    localparam vec_t GRA       = vec_t'(1) << 21;
    localparam vec_t GRB       = vec_t'(1) << 22;
    localparam vec_t GRC       = vec_t'(1) << 23;
    localparam vec_t CONIN     = vec_t'(1) << 24;
    localparam vec_t INCPC     = vec_t'(1) << 25;
    localparam vec_t READ      = vec_t'(1) << 26;
    localparam vec_t WRITE     = vec_t'(1) << 27;
    localparam vec_t CADD      = vec_t'(8) << 28;
    localparam vec_t MDRMEM    = vec_t'(1) << 32;
    localparam vec_t RUN       = vec_t'(1) << 34;

    localparam logic [4:0] T_LD = 5'h00, T_LDI = 5'h01, T_ST = 5'h02, T_ADD = 5'h03;
    localparam logic [4:0] T_SUB = 5'h04, T_AND = 5'h05, T_OR = 5'h06, T_ADDI = 5'h0C;
    localparam logic [4:0] T_ANDI = 5'h0D, T_ORI = 5'h0E, T_BR = 5'h12, T_JR = 5'h13;
    localparam logic [4:0] T_IN = 5'h16, T_OUT = 5'h17, T_MFHI = 5'h18, T_MFLO = 5'h19;
    localparam logic [4:0] T_NOP = 5'h1A, T_HALT = 5'h1B;

    logic clk = 1'b1;
    logic reset;
    control_sequencer_if bus();

    control_sequencer #(.OPW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_instr = 0;
    int   cyc = 0;
    vec_t mon_e, mon_g;

    function automatic vec_t sample();
        vec_t v;
        v = '0;
        v[0] = bus.PCout;   v[1] = bus.Zlowout;  v[2] = bus.Zhighout;   v[3] = bus.MDRout;
        v[4] = bus.HIout;   v[5] = bus.LOout;    v[6] = bus.InPortout;  v[7] = bus.Cout;
        v[8] = bus.BAout;   v[9] = bus.Rout;     v[10] = bus.MARin;     v[11] = bus.PCin;
        v[12] = bus.MDRin;  v[13] = bus.IRin;    v[14] = bus.Yin;       v[15] = bus.Zlowin;
        v[16] = bus.Zhighin; v[17] = bus.HIin;   v[18] = bus.LOin;      v[19] = bus.OutPortin;
        v[20] = bus.Rin;    v[21] = bus.GRA;     v[22] = bus.GRB;       v[23] = bus.GRC;
        v[24] = bus.CONin;  v[25] = bus.IncPc;   v[26] = bus.read;      v[27] = bus.write;
        v[31:28] = bus.control;
        v[33:32] = bus.mdr_read;
        v[34] = bus.Run;
        return v;
    endfunction

    task automatic check(input string name, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference microprogram: one vector per cycle, straight from the step tables.
    function automatic int model(input logic [4:0] op, input bit b, output vec_t s[8]);
        int   n;
        vec_t cv;
        cv = (op == T_SUB) ? (vec_t'(9) << 28) :
             (op == T_AND || op == T_ANDI) ? (vec_t'(1) << 28) :
             (op == T_OR  || op == T_ORI)  ? (vec_t'(2) << 28) : CADD;
        for (int i = 0; i < 8; i++) s[i] = RUN;
        s[0] |= PCOUT | MARIN | INCPC | ZLOWIN;
        s[1] |= ZLOWOUT | PCIN | READ | MDRMEM | MDRIN;
        s[2] |= MDROUT | IRIN;
        n = 4;
        case (op)
            T_ADD, T_SUB, T_AND, T_OR: begin
                s[3] |= GRB | ROUT | YIN; s[4] |= GRC | ROUT | cv | ZLOWIN;
                s[5] |= ZLOWOUT | GRA | RIN; n = 6;
            end
            T_ADDI, T_ANDI, T_ORI, T_LDI: begin
                s[3] |= GRB | BAOUT | YIN; s[4] |= COUT | cv | ZLOWIN;
                s[5] |= ZLOWOUT | GRA | RIN; n = 6;
            end
            T_LD: begin
                s[3] |= GRB | BAOUT | YIN; s[4] |= COUT | CADD | ZLOWIN; s[5] |= ZLOWOUT | MARIN;
                s[6] |= READ | MDRMEM | MDRIN; s[7] |= MDROUT | GRA | RIN; n = 8;
            end
            T_ST: begin
                s[3] |= GRB | BAOUT | YIN; s[4] |= COUT | CADD | ZLOWIN; s[5] |= ZLOWOUT | MARIN;
                s[6] |= GRA | ROUT | MDRIN; s[7] |= WRITE; n = 8;
            end
            T_BR: begin
                s[3] |= GRA | ROUT | CONIN; s[4] |= PCOUT | YIN; s[5] |= COUT | CADD | ZLOWIN;
                s[6] |= ZLOWOUT | (b ? PCIN : vec_t'(0)); n = 7;
            end
            T_JR:   s[3] |= GRA | ROUT | PCIN;
            T_IN:   s[3] |= INPORTOUT | GRA | RIN;
            T_OUT:  s[3] |= GRA | ROUT | OUTPORTIN;
            T_MFHI: s[3] |= HIOUT | GRA | RIN;
            T_MFLO: s[3] |= LOOUT | GRA | RIN;
            default: n = 4;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_g = sample();
            checks++;
            if (mon_g !== mon_e) begin
                errors++;
                $display("FAIL step@cycle%0d IR=%h: got %h expected %h", cyc, bus.IR, mon_g, mon_e);
            end
        end
    end

    // After entering HALT: ten silent cycles, then reset and release.
    task automatic halt_then_restart();
        @(negedge clk); #1;
        bus.stop = 1'b0;
        repeat (10) exp_q.push_back('0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("halt_reset_outputs", sample(), '0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Called in the high phase of the step preceding this instruction's T0.
    // smode: 0 = no stop, 1 = stop pulse inside fetch (ignored), 2 = stop over last step.
    task automatic run_instr(input logic [31:0] ir, input bit b, input int smode);
        vec_t s[8];
        int   n;
        logic [4:0] op;
        op = ir[31:27];
        n  = model(op, b, s);
        @(negedge clk); #1;
        bus.IR     = ir;
        bus.Branch = b;
        for (int i = 0; i < n; i++) exp_q.push_back(s[i]);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (smode == 1 && k == 1) bus.stop = 1'b1;
            if (smode == 1 && k == 2) bus.stop = 1'b0;
            if (smode == 2 && k == n - 1) bus.stop = 1'b1;
        end
        n_instr++;
        $display("instr %0d: IR=%h op=%02h Branch=%0d stop_mode=%0d cycles=%0d",
                 n_instr, ir, op, b, smode, n);
        if (op == T_HALT || smode == 2) halt_then_restart();
    endtask

    logic [4:0] op_tab [16];
    initial begin
        vec_t       s[8];
        int         n;
        int         r;
        logic [4:0] op;

        op_tab = '{T_LD, T_LDI, T_ST, T_ADD, T_SUB, T_AND, T_OR, T_ADDI,
                   T_ANDI, T_ORI, T_BR, T_JR, T_IN, T_OUT, T_MFHI, T_MFLO};
        reset = 1'b1; bus.IR = '0; bus.Branch = 1'b0; bus.stop = 1'b0;
        #1;
        check("reset_state", sample(), '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // add aborted by reset in the middle of T4
        n = model(T_ADD, 1'b0, s);
        @(negedge clk); #1;
        bus.IR = 32'h18918000;
        for (int i = 0; i < 5; i++) exp_q.push_back(s[i]);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset_mid_T4_async", sample(), '0);
        @(posedge clk); #1;
        reset = 1'b0;
        $display("instr: add aborted by reset in T4 (%0d-cycle program)", n);

        run_instr(32'h18918000, 1'b0, 0);
        run_instr({T_LD, 27'h0123456}, 1'b0, 0);
        run_instr({T_ST, 27'h0654321}, 1'b1, 0);
        run_instr({T_BR, 27'h0000010}, 1'b0, 0);
        run_instr({T_BR, 27'h0000010}, 1'b1, 0);
        run_instr({T_ADD, 27'h0000000}, 1'b0, 1);
        run_instr({T_OR, 27'h1234567}, 1'b0, 2);
        run_instr({T_NOP, 27'h0}, 1'b0, 0);
        run_instr({T_HALT, 27'h0}, 1'b0, 0);

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
            else                           op = op_tab[$urandom_range(0, 15)];
            r = $urandom_range(0, 19);
            run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)),
                      (r == 0) ? 2 : (r <= 3) ? 1 : 0);
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
